// File: rtl/mux_using_assign_pkg.sv
// Shared constants for the mux_using_assign slice: counter width, saturation
// value and reset values of the registered outputs.
package mux_using_assign_pkg;

    localparam int unsigned    CNT_W             = 16;
    localparam logic [15:0]    CNT_MAX           = 16'hFFFF;
    localparam logic [15:0]    CNT_RST           = 16'h0000;
    localparam logic           MUX_OUT_Q_RST_BIT = 1'b0;
    localparam logic           SEL_Q_RST         = 1'b0;

endpackage

// File: rtl/mux_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module mux_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX_VAL = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE_VAL = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: step by one unless already saturated.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (inc && (cnt_r != MAX_VAL)) begin
            cnt_nxt_s = cnt_r + ONE_VAL;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/mux_using_assign.sv
// 2:1 mux with combinational output plus registered copies of output and select.
// Define MUX_USING_ASSIGN_TOGGLE_CNT_EN to build the saturating sel-toggle counter.
module mux_using_assign
    import mux_using_assign_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_0,
    input  logic [WIDTH-1:0] din_1,
    input  logic             sel,
    output logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] mux_out_q,
    output logic             sel_q,
    output logic [15:0]      sel_toggle_cnt
);

    logic [WIDTH-1:0] mux_out_q_r;
    logic             sel_q_r;

    // Zero-latency select; independent of clock and reset.
    assign mux_out = sel ? din_1 : din_0;

    // Registered copies of the mux output and select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_out_q_r <= {WIDTH{MUX_OUT_Q_RST_BIT}};
            sel_q_r     <= SEL_Q_RST;
        end else begin
            mux_out_q_r <= mux_out;
            sel_q_r     <= sel;
        end
    end

    assign mux_out_q = mux_out_q_r;
    assign sel_q     = sel_q_r;

`ifdef MUX_USING_ASSIGN_TOGGLE_CNT_EN
    logic             sel_toggle_s;
    logic [CNT_W-1:0] cnt_s;

    // A held change is seen only once because sel_q catches up after one edge.
    assign sel_toggle_s = sel ^ sel_q_r;

    mux_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sel_toggle_s),
        .cnt   (cnt_s)
    );

    assign sel_toggle_cnt = cnt_s;
`else
    assign sel_toggle_cnt = CNT_RST;
`endif

endmodule

// File: tb/tb_mux_using_assign.sv
// Scoreboard bench for mux_using_assign: stimulus queues expectations,
// an independent monitor samples the DUTs and compares.
module tb_mux_using_assign;

`ifdef MUX_USING_ASSIGN_TOGGLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int K_OUT1  = 0;
    localparam int K_OUT8  = 1;
    localparam int K_OUTQ8 = 2;
    localparam int K_SELQ  = 3;
    localparam int K_CNT   = 4;

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [0:0]  d1_0, d1_1, out1, outq1;
    logic [7:0]  d8_0, d8_1, out8, outq8;
    logic        selq1, selq8;
    logic [15:0] cnt1, cnt8;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    bit   stim_done;

    mux_using_assign #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .din_0 (d1_0), .din_1 (d1_1), .sel (sel),
        .mux_out (out1), .mux_out_q (outq1), .sel_q (selq1), .sel_toggle_cnt (cnt1)
    );

    mux_using_assign #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst_n (rst_n), .din_0 (d8_0), .din_1 (d8_1), .sel (sel),
        .mux_out (out8), .mux_out_q (outq8), .sel_q (selq8), .sel_toggle_cnt (cnt8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] cnt_exp(input logic [15:0] v);
        return CNT_EN ? v : 16'h0000;
    endfunction

    task automatic push(input int kind, input logic [15:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Monitor: sample 1 ns after expectations appear and compare.
    initial begin
        exp_t        e;
        logic [15:0] act;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            wait (exp_q.size() != 0);
            #1;
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_OUT1:  act = {15'h0000, out1};
                    K_OUT8:  act = {8'h00, out8};
                    K_OUTQ8: act = {8'h00, outq8};
                    K_SELQ:  act = {15'h0000, selq8};
                    K_CNT:   act = cnt8;
                    default: act = 16'hDEAD;
                endcase
                n_cmp = n_cmp + 1;
                if (act !== e.val) begin
                    n_bad = n_bad + 1;
                    $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_done = 1'b0;
        rst_n = 1'b0;
        sel   = 1'b0;
        d1_0  = 1'b0; d1_1 = 1'b1;
        d8_0  = 8'hA5; d8_1 = 8'h3C;

        // Combinational truth table, exercised while held in reset.
        #10 push(K_OUT1, 16'h0000, "truth_d0_0_sel0");
        push(K_OUT8, 16'h00A5, "out8_in_reset");
        push(K_OUTQ8, 16'h0000, "rst_mux_out_q");
        push(K_SELQ, 16'h0000, "rst_sel_q");
        push(K_CNT, 16'h0000, "rst_cnt");
        #10 sel = 1'b1;
        #10 push(K_OUT1, 16'h0001, "truth_d1_1_sel1");
        #10 sel = 1'b0; d1_0 = 1'b1;
        #10 push(K_OUT1, 16'h0001, "truth_d0_1_sel0");
        #10 sel = 1'b1; d1_1 = 1'b0;
        #10 push(K_OUT1, 16'h0000, "truth_d1_0_sel1");
        #10 sel = 1'b0; d1_0 = 1'b1; d1_1 = 1'b1;
        #10 push(K_OUT1, 16'h0001, "truth_both1_sel0");
        #10 sel = 1'b1;
        #10 push(K_OUT1, 16'h0001, "truth_both1_sel1");

        // Registered path.
        @(negedge clk);
        sel = 1'b0; rst_n = 1'b1;
        @(posedge clk); #2;
        push(K_OUTQ8, 16'h00A5, "q_after_release");
        push(K_SELQ, 16'h0000, "selq_after_release");
        push(K_CNT, cnt_exp(16'd0), "cnt_no_toggle");
        @(negedge clk);
        sel = 1'b1;
        #1;
        push(K_OUT8, 16'h003C, "out8_immediate");
        push(K_OUTQ8, 16'h00A5, "q_not_yet");
        @(posedge clk); #2;
        push(K_OUTQ8, 16'h003C, "q_one_cycle");
        push(K_SELQ, 16'h0001, "selq_one_cycle");
        push(K_CNT, cnt_exp(16'd1), "cnt_first_toggle");

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        push(K_OUTQ8, 16'h0000, "async_rst_q");
        push(K_SELQ, 16'h0000, "async_rst_selq");
        push(K_CNT, 16'h0000, "async_rst_cnt");
        push(K_OUT8, 16'h003C, "async_rst_out8");

        // Toggle count: alternate sel for 5 cycles starting at 1, then hold.
        @(negedge clk);
        rst_n = 1'b1;
        sel   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            push(K_CNT, cnt_exp(16'(i + 1)), "toggle_cnt");
            @(negedge clk);
            if (i < 4) sel = ~sel;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            push(K_CNT, cnt_exp(16'd5), "hold_cnt");
        end

        // Saturation: toggle every cycle well past 16'hFFFF.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            sel = k[0];
            if (k == 65534 || k == 65535 || k == 65540) begin
                @(posedge clk); #2;
                push(K_CNT, cnt_exp((k == 65534) ? 16'hFFFE : 16'hFFFF), "sat_cnt");
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            push(K_CNT, cnt_exp(16'hFFFF), "sat_hold");
        end
        stim_done = 1'b1;
    end

    initial begin
        wait (stim_done);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
